// File: rtl/display_scan_ctrl.sv
// Display entry bank with auto-scroll, debounced manual step and freeze, feeding a 7-bit segment driver.
// Optional build macro DISPLAY_SATURATE_EN: saturate stored values to 127 instead of truncating to 7 bits.
module display_scan_ctrl #(
  parameter int NUM_ENTRIES     = 8,
  parameter int DATA_W          = 32,
  parameter int DWELL_CYCLES    = 50000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [$clog2(NUM_ENTRIES)-1:0] wr_addr,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           btn_next,
  input  logic                           mode_auto,
  input  logic                           freeze,
  output logic [6:0]                     disp_value,
  output logic [$clog2(NUM_ENTRIES)-1:0] disp_index,
  output logic                           disp_valid,
  output logic                           ovf_flag
);

  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int CW = $clog2(DWELL_CYCLES);
  localparam int BW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_AUTO, S_MANUAL, S_FROZEN} state_t;

  state_t           state_q, state_d;
  logic [6:0]       entry_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    next_idx;
  logic             advance;

  logic             sync1_q, sync2_q;
  logic             db_level_q, db_prev_q;
  logic [BW-1:0]    db_cnt_q;
  logic             step;

  logic             wr_over;
  logic [6:0]       wr_conv;

  always_comb begin
    wr_over = wr_data > DATA_W'(127);
`ifdef DISPLAY_SATURATE_EN
    wr_conv = wr_over ? 7'd127 : wr_data[6:0];
`else
    wr_conv = wr_data[6:0];
`endif
  end

  // Entry storage and sticky overflow; writes land in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= '0;
      valid_q  <= '0;
      ovf_flag <= 1'b0;
    end else if (wr_en) begin
      entry_q[wr_addr] <= wr_conv;
      valid_q[wr_addr] <= 1'b1;
      if (wr_over) ovf_flag <= 1'b1;
    end
  end

  // Two-flop synchronizer, then a level that flips only after a full stable run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q   <= btn_next;
      sync2_q   <= sync1_q;
      db_prev_q <= db_level_q;
      if (sync2_q != db_level_q) begin
        if (db_cnt_q == DEB_LAST) begin
          db_level_q <= sync2_q;
          db_cnt_q   <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + BW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign step = db_level_q & ~db_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_AUTO;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Step and terminal count are OR-ed so a coincidence yields a single advance.
  always_comb begin
    state_d  = freeze ? S_FROZEN : (mode_auto ? S_AUTO : S_MANUAL);
    advance  = 1'b0;
    cnt_d    = '0;
    next_idx = disp_index;
    case (state_q)
      S_AUTO: begin
        advance = step | (cnt_q == DWELL_LAST);
        cnt_d   = advance ? '0 : cnt_q + CW'(1);
      end
      S_MANUAL: advance = step;
      S_FROZEN: advance = 1'b0;
      default:  advance = 1'b0;
    endcase
    if (advance) next_idx = disp_index + IW'(1);
  end

  // disp_index doubles as the scan index register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_index <= '0;
      disp_value <= '0;
      disp_valid <= 1'b0;
    end else if (state_q != S_FROZEN) begin
      disp_index <= next_idx;
      if (wr_en && (wr_addr == next_idx)) begin
        disp_value <= wr_conv;
        disp_valid <= 1'b1;
      end else begin
        disp_value <= entry_q[next_idx];
        disp_valid <= valid_q[next_idx];
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: stimulus queues cycle-stamped expectations, a negedge monitor checks them.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst, wr_en, btn_next, mode_auto, freeze;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  disp_value;
  logic [2:0]  disp_index;
  logic        disp_valid, ovf_flag;

`ifdef DISPLAY_SATURATE_EN
  localparam logic [6:0] OVF_V = 7'd127;
`else
  localparam logic [6:0] OVF_V = 7'd72;
`endif

  display_scan_ctrl #(
    .NUM_ENTRIES(8), .DATA_W(32), .DWELL_CYCLES(4), .DEBOUNCE_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .btn_next(btn_next), .mode_auto(mode_auto), .freeze(freeze),
    .disp_value(disp_value), .disp_index(disp_index), .disp_valid(disp_valid),
    .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] idx;
    logic [6:0] val;
    logic       vld;
    logic       ovf;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  task automatic expect_at(input int k, input logic [2:0] idx, input logic [6:0] val,
                           input logic vld, input logic ovf, input string name);
    exp_t e;
    e.cyc = cyc + k;
    e.idx = idx;
    e.val = val;
    e.vld = vld;
    e.ovf = ovf;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if (e.cyc != cyc || disp_index !== e.idx || disp_value !== e.val ||
          disp_valid !== e.vld || ovf_flag !== e.ovf) begin
        n_fail++;
        $display("FAIL %s cyc=%0d due=%0d: got idx=%0d val=%0d vld=%0b ovf=%0b, expected idx=%0d val=%0d vld=%0b ovf=%0b",
                 nm, cyc, e.cyc, disp_index, disp_value, disp_valid, ovf_flag,
                 e.idx, e.val, e.vld, e.ovf);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset is asserted between edges, so outputs must clear before the next edge.
  task automatic do_reset();
    rst       = 1'b1;
    wr_en     = 1'b0;
    btn_next  = 1'b0;
    freeze    = 1'b0;
    mode_auto = 1'b1;
    expect_at(0, 3'd0, 7'd0, 1'b0, 1'b0, "reset_async");
    expect_at(1, 3'd0, 7'd0, 1'b0, 1'b0, "reset_hold");
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d: got no end of stimulus, expected finish", cyc);
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    btn_next = 1'b0; mode_auto = 1'b1; freeze = 1'b0;
    tick();

    // Auto walk over all eight entries, 4 cycles each, wrapping to 0.
    do_reset();
    for (int k = 1; k <= 35; k++) begin
      int id;
      id = (k / 4) % 8;
      expect_at(k, 3'(id), (id == 0) ? 7'd42 : ((id == 1) ? 7'd99 : 7'd0),
                (id <= 1), 1'b0, "auto_walk");
    end
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'd42;
    tick();
    wr_addr = 3'd1; wr_data = 32'd99;
    tick();
    wr_en = 1'b0;
    repeat (34) tick();

    // 127 is the largest non-overflowing value; 200 overflows.
    do_reset();
    expect_at(1,  3'd0, 7'd127, 1'b1, 1'b0, "write_127_no_ovf");
    expect_at(2,  3'd0, 7'd127, 1'b1, 1'b1, "ovf_set");
    expect_at(3,  3'd0, 7'd127, 1'b1, 1'b1, "ovf_sticky");
    expect_at(11, 3'd2, 7'd0,   1'b0, 1'b1, "ovf_idx2");
    expect_at(12, 3'd3, OVF_V,  1'b1, 1'b1, "ovf_conv");
    expect_at(15, 3'd3, OVF_V,  1'b1, 1'b1, "ovf_conv_hold");
    expect_at(16, 3'd4, 7'd0,   1'b0, 1'b1, "ovf_idx4");
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'd127;
    tick();
    wr_addr = 3'd3; wr_data = 32'd200;
    tick();
    wr_en = 1'b0;
    repeat (15) tick();

    // Manual: short pulses rejected, long hold advances once 6 cycles after it starts.
    do_reset();
    mode_auto = 1'b0;
    for (int k = 1; k <= 30; k++)
      expect_at(k, (k >= 17) ? 3'd1 : 3'd0, 7'd0, 1'b0, 1'b0,
                (k >= 17) ? "btn_advance" : "btn_no_advance");
    tick();
    btn_next = 1'b1;
    tick();
    btn_next = 1'b0;
    repeat (3) tick();
    btn_next = 1'b1;
    repeat (2) tick();
    btn_next = 1'b0;
    repeat (4) tick();
    btn_next = 1'b1;
    repeat (10) tick();
    btn_next = 1'b0;
    repeat (10) tick();

    // Write to entry 5 on the same edge the display moves onto it.
    do_reset();
    expect_at(19, 3'd4, 7'd0,  1'b0, 1'b0, "bypass_before");
    expect_at(20, 3'd5, 7'd17, 1'b1, 1'b0, "bypass_hit");
    expect_at(21, 3'd5, 7'd17, 1'b1, 1'b0, "bypass_stored");
    expect_at(24, 3'd6, 7'd0,  1'b0, 1'b0, "bypass_after");
    repeat (19) tick();
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'd17;
    tick();
    wr_en = 1'b0;
    repeat (5) tick();

    // Freeze on index 2, write and press underneath, then release.
    do_reset();
    expect_at(7, 3'd1, 7'd0, 1'b0, 1'b0, "frz_pre");
    for (int k = 8; k <= 27; k++) expect_at(k, 3'd2, 7'd42, 1'b1, 1'b0, "frz_hold");
    for (int k = 28; k <= 30; k++) expect_at(k, 3'd2, 7'd7, 1'b1, 1'b0, "frz_refresh");
    expect_at(31, 3'd3, 7'd0, 1'b0, 1'b0, "frz_dwell_restart");
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'd42;
    tick();
    wr_en = 1'b0;
    repeat (7) tick();
    freeze = 1'b1;
    repeat (2) tick();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'd7;
    tick();
    wr_en = 1'b0;
    tick();
    btn_next = 1'b1;
    repeat (8) tick();
    btn_next = 1'b0;
    repeat (6) tick();
    freeze = 1'b0;
    repeat (6) tick();

    // Debounced step coincides with the terminal dwell cycle, then reset mid-dwell.
    do_reset();
    expect_at(1, 3'd0, 7'd42, 1'b1, 1'b0, "coin_wr0");
    expect_at(2, 3'd0, 7'd42, 1'b1, 1'b1, "coin_ovf");
    expect_at(3, 3'd0, 7'd42, 1'b1, 1'b1, "coin_idx0");
    for (int k = 4; k <= 7; k++)   expect_at(k, 3'd1, 7'd0, 1'b0, 1'b1, "coin_idx1");
    for (int k = 8; k <= 11; k++)  expect_at(k, 3'd2, 7'd0, 1'b0, 1'b1, "coin_single_adv");
    for (int k = 12; k <= 13; k++) expect_at(k, 3'd3, 7'd0, 1'b0, 1'b1, "coin_idx3");
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 32'd42;
    tick();
    wr_addr = 3'd7; wr_data = 32'd200;
    tick();
    wr_en = 1'b0;
    btn_next = 1'b1;
    repeat (7) tick();
    btn_next = 1'b0;
    repeat (5) tick();
    do_reset();
    for (int k = 1; k <= 3; k++) expect_at(k, 3'd0, 7'd0, 1'b0, 1'b0, "post_reset_idx0");
    expect_at(4, 3'd1, 7'd0, 1'b0, 1'b0, "post_reset_adv");
    repeat (5) tick();

    repeat (2) tick();
    if (exp_q.size() != 0) begin
      $display("FAIL leftover: got %0d unchecked expectations, expected 0", exp_q.size());
      n_fail += exp_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
